// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit for the execute stage.
// Define MULTDIV_RADIX4_EN for a radix-4 Booth multiply (WIDTH/2 iterations).
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
`ifdef MULTDIV_RADIX4_EN
  localparam int MULN = WIDTH / 2;
`else
  localparam int MULN = WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE, MUL, DIV, DONE
  } state_t;

  state_t state, nxt;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   ma;
  logic               neg;
  logic               dz;
`ifdef MULTDIV_RADIX4_EN
  logic [2*WIDTH-1:0] m;
  logic [WIDTH:0]     b;
  logic [2*WIDTH-1:0] pp;
`else
  logic [WIDTH:0]     msum;
`endif

  logic               start;
  logic               fin;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [2*WIDTH-1:0] div_nxt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     rs;
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   res_c;
  logic               exc_c;

  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] x
  );
    return x[WIDTH-1] ? -x : x;
  endfunction

  assign start = ctrl_MULT ^ ctrl_DIV;
  assign fin   = (state == MUL && cnt == CW'(MULN))
              || (state == DIV && cnt == CW'(WIDTH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     nxt = IDLE;
      MUL, DIV: if (fin) nxt = DONE;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
    // a valid start always wins, aborting any op in flight
    if (start) nxt = ctrl_MULT ? MUL : DIV;
  end

  always_comb begin
    data_resultRDY = (state == DONE);
    busy           = (state != IDLE);
  end

  always_comb begin
`ifdef MULTDIV_RADIX4_EN
    unique case (b[2:0])
      3'b001, 3'b010: pp = m;
      3'b011:         pp = m << 1;
      3'b100:         pp = -(m << 1);
      3'b101, 3'b110: pp = -m;
      default:        pp = '0;
    endcase
    mul_nxt = p + pp;
    prod    = p;
`else
    msum    = {1'b0, p[2*WIDTH-1:WIDTH]}
            + (p[0] ? {1'b0, ma} : '0);
    mul_nxt = {msum, p[WIDTH-1:1]};
    prod    = neg ? -p : p;
`endif
    // remainder stays below the divisor, so WIDTH bits suffice
    rs      = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    ge      = rs >= {1'b0, ma};
    diff    = rs[WIDTH-1:0] - ma;
    div_nxt = ge ? {diff, p[WIDTH-2:0], 1'b1}
                 : {rs[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
    q       = neg ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    if (state == MUL) begin
      res_c = prod[WIDTH-1:0];
      exc_c = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
    end else begin
      res_c = dz ? '0 : q;
      exc_c = dz | (~neg & p[WIDTH-1]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt            <= '0;
      p              <= '0;
      ma             <= '0;
      neg            <= 1'b0;
      dz             <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
`ifdef MULTDIV_RADIX4_EN
      m              <= '0;
      b              <= '0;
`endif
    end else if (start) begin
      neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      cnt <= '0;
      dz  <= 1'b0;
      if (ctrl_MULT) begin
        ma <= mag(data_operandA);
`ifdef MULTDIV_RADIX4_EN
        p  <= '0;
        m  <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
        b  <= {data_operandB, 1'b0};
`else
        p  <= {{WIDTH{1'b0}}, mag(data_operandB)};
`endif
      end else begin
        ma <= mag(data_operandB);
        p  <= {{WIDTH{1'b0}}, mag(data_operandA)};
        if (data_operandB == '0) begin
          dz  <= 1'b1;
          cnt <= CW'(WIDTH);
        end
      end
    end else if (fin) begin
      data_result    <= res_c;
      data_exception <= exc_c;
    end else if (state == MUL) begin
      cnt <= cnt + 1'b1;
      p   <= mul_nxt;
`ifdef MULTDIV_RADIX4_EN
      m   <= m << 2;
      b   <= {{2{b[WIDTH]}}, b[WIDTH:2]};
`endif
    end else if (state == DIV) begin
      cnt <= cnt + 1'b1;
      p   <= div_nxt;
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: latency, results, exceptions,
// restart, start collision and asynchronous reset.
module tb_multdiv_unit;

`ifdef MULTDIV_RADIX4_EN
  localparam int MLAT = 17;
`else
  localparam int MLAT = 33;
`endif
  localparam int DLAT = 33;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int total;
  int passed;
  int fails;
  int rdycnt;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_op(
    input logic        mul,
    input logic [31:0] a,
    input logic [31:0] b
  );
    @(negedge clock);
    ctrl_MULT     = mul;
    ctrl_DIV      = ~mul;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_op(
    input string       tag,
    input int          lat,
    input logic [31:0] res,
    input logic        exc
  );
    int n;
    n = 0;
    while (n < 100) begin
      @(posedge clock);
      n++;
      #1;
      if (data_resultRDY) break;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_res"}, 64'(data_result), 64'(res));
    chk({tag, "_exc"}, 64'(data_exception), 64'(exc));
    @(posedge clock);
    #1;
    chk({tag, "_rdy_off"}, 64'(data_resultRDY), 64'd0);
    chk({tag, "_busy_off"}, 64'(busy), 64'd0);
  endtask

  initial begin
    total         = 0;
    passed        = 0;
    fails         = 0;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_res", 64'(data_result), 64'd0);
    chk("rst_exc", 64'(data_exception), 64'd0);
    chk("rst_rdy", 64'(data_resultRDY), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    start_op(1'b1, 32'd7, 32'hFFFF_FFFD);
    chk("m1_busy", 64'(busy), 64'd1);
    wait_op("m1", MLAT, 32'hFFFF_FFEB, 1'b0);

    start_op(1'b1, 32'h0001_0000, 32'h0001_0000);
    wait_op("m2", MLAT, 32'h0000_0000, 1'b1);

    start_op(1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFA);
    wait_op("m3", MLAT, 32'd30, 1'b0);

    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_op("m4", MLAT, 32'h8000_0000, 1'b1);

    start_op(1'b0, 32'hFFFF_FF9C, 32'd7);
    wait_op("d1", DLAT, 32'hFFFF_FFF2, 1'b0);

    start_op(1'b0, 32'd5, 32'd0);
    wait_op("d0", 1, 32'd0, 1'b1);

    start_op(1'b0, 32'd100, 32'hFFFF_FFF9);
    wait_op("d2", DLAT, 32'hFFFF_FFF2, 1'b0);

    start_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_op("dovf", DLAT, 32'h8000_0000, 1'b1);

    start_op(1'b1, 32'd3, 32'd4);
    rdycnt = 0;
    repeat (9) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdycnt++;
    end
    chk("abort_no_rdy", 64'(rdycnt), 64'd0);
    start_op(1'b0, 32'd20, 32'd5);
    wait_op("restart", DLAT, 32'd4, 1'b0);

    @(negedge clock);
    ctrl_MULT = 1'b1;
    ctrl_DIV  = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    chk("both_busy", 64'(busy), 64'd0);
    @(posedge clock);
    #1;
    chk("both_busy2", 64'(busy), 64'd0);
    chk("both_rdy", 64'(data_resultRDY), 64'd0);

    start_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_op("pre_rst", DLAT, 32'h8000_0000, 1'b1);
    start_op(1'b1, 32'd5, 32'd5);
    repeat (5) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_res", 64'(data_result), 64'd0);
    chk("arst_exc", 64'(data_exception), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_rdy", 64'(data_resultRDY), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    start_op(1'b1, 32'd2, 32'd2);
    wait_op("post_rst", MLAT, 32'd4, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
